// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory bus between instruction fetch (I) and load/store (D).
// D has priority; a streak counter forces an I grant after MAX_DSTREAK D grants while I waits.
//
// state   | meaning
// IDLE    | bus free, grant the next requester
// WAITING | bus request outstanding, m_req_* held stable
// OVER    | one-cycle response slot to the owner, no new grant
module mem_bus_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req_valid,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_resp_ok,
  output logic [DATA_W-1:0]   i_resp_data,
  input  logic                d_req_valid,
  input  logic                d_req_write,
  input  logic [2:0]          d_req_size,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_strobe,
  output logic                d_resp_ok,
  output logic [DATA_W-1:0]   d_resp_data,
  output logic                m_req_valid,
  output logic                m_req_write,
  output logic [2:0]          m_req_size,
  output logic [ADDR_W-1:0]   m_req_addr,
  output logic [DATA_W-1:0]   m_req_wdata,
  output logic [DATA_W/8-1:0] m_req_strobe,
  input  logic                m_resp_ready,
  input  logic [DATA_W-1:0]   m_resp_data,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, WAITING, OVER} mem_access_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);
  localparam logic [2:0] FETCH_SIZE = 3'b010;

  mem_access_state_t state;
  owner_t            owner;
  logic [3:0]        streak;
  logic              d_wins;

  assign d_wins = d_req_valid && !(i_req_valid && (streak == STREAK_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= OWN_I;
      streak       <= '0;
      busy         <= 1'b0;
      i_resp_ok    <= 1'b0;
      i_resp_data  <= '0;
      d_resp_ok    <= 1'b0;
      d_resp_data  <= '0;
      m_req_valid  <= 1'b0;
      m_req_write  <= 1'b0;
      m_req_size   <= '0;
      m_req_addr   <= '0;
      m_req_wdata  <= '0;
      m_req_strobe <= '0;
    end else begin
      i_resp_ok <= 1'b0;
      d_resp_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (d_wins) begin
            state        <= WAITING;
            owner        <= OWN_D;
            busy         <= 1'b1;
            m_req_valid  <= 1'b1;
            m_req_write  <= d_req_write;
            m_req_size   <= d_req_size;
            m_req_addr   <= d_req_addr;
            m_req_wdata  <= d_req_wdata;
            m_req_strobe <= d_req_write ? d_req_strobe : '0;
            if (!i_req_valid)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + 4'd1;
          end else if (i_req_valid) begin
            state        <= WAITING;
            owner        <= OWN_I;
            busy         <= 1'b1;
            m_req_valid  <= 1'b1;
            m_req_write  <= 1'b0;
            m_req_size   <= FETCH_SIZE;
            m_req_addr   <= i_req_addr;
            m_req_wdata  <= '0;
            m_req_strobe <= '0;
            streak       <= '0;
          end
        end
        WAITING: begin
          // Response pulse is decided at the completion edge so it is visible in OVER;
          // a requester that withdrew its valid gets nothing (flushed).
          if (m_resp_ready) begin
            state       <= OVER;
            m_req_valid <= 1'b0;
            if (owner == OWN_D) begin
              if (d_req_valid) begin
                d_resp_ok   <= 1'b1;
                d_resp_data <= m_resp_data;
              end
            end else if (i_req_valid) begin
              i_resp_ok   <= 1'b1;
              i_resp_data <= m_resp_data;
            end
          end
        end
        OVER: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: transaction-level reference model predicts grants and
// responses; a monitor compares DUT bus requests and response pulses against the queues.
module tb_mem_bus_arbiter;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic [63:0] i_req_addr = '0;
  logic        i_resp_ok;
  logic [63:0] i_resp_data;
  logic        d_req_valid = 1'b0;
  logic        d_req_write = 1'b0;
  logic [2:0]  d_req_size = '0;
  logic [63:0] d_req_addr = '0;
  logic [63:0] d_req_wdata = '0;
  logic [7:0]  d_req_strobe = '0;
  logic        d_resp_ok;
  logic [63:0] d_resp_data;
  logic        m_req_valid;
  logic        m_req_write;
  logic [2:0]  m_req_size;
  logic [63:0] m_req_addr;
  logic [63:0] m_req_wdata;
  logic [7:0]  m_req_strobe;
  logic        m_resp_ready = 1'b0;
  logic [63:0] m_resp_data = '0;
  logic        busy;

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_DSTREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .i_resp_ok(i_resp_ok), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_size(d_req_size),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_strobe(d_req_strobe),
    .d_resp_ok(d_resp_ok), .d_resp_data(d_resp_data),
    .m_req_valid(m_req_valid), .m_req_write(m_req_write), .m_req_size(m_req_size),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_strobe(m_req_strobe),
    .m_resp_ready(m_resp_ready), .m_resp_data(m_resp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          own_d;
    logic        wr;
    logic [2:0]  sz;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    bit          chk_wd;
  } bus_t;

  typedef struct {
    bit          own_d;
    logic [63:0] data;
    int          cyc;
  } resp_t;

  bus_t  exp_bus[$];
  resp_t exp_resp[$];
  bit    grant_log[$];
  int    i_ok_cnt = 0;
  int    d_ok_cnt = 0;

  // Reference model: bus is free two cycles after completion; D wins unless I has
  // waited through MAXS consecutive D grants.
  bit model_en = 0;
  bit pending = 0;
  bit mdl_owner_d = 0;
  int grant_c = 0;
  int ready_c = -10;
  int streak = 0;
  int i_age = 0;
  int d_age = 0;

  always @(negedge clk) begin
    bit   exp_mv, exp_busy, give_d;
    bus_t b;
    if (model_en) begin
      exp_mv   = pending && (cyc > grant_c);
      exp_busy = exp_mv || (cyc == ready_c + 1);
      checks += 2;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy: cyc=%0d got %b expected %b", cyc, busy, exp_busy);
      end
      if (m_req_valid !== exp_mv) begin
        errors++;
        $display("FAIL m_req_valid: cyc=%0d got %b expected %b", cyc, m_req_valid, exp_mv);
      end
      if (reset) begin
        pending = 0;
        streak  = 0;
        ready_c = -10;
      end else if (exp_mv) begin
        if (m_resp_ready) begin
          pending = 0;
          ready_c = cyc;
          if (mdl_owner_d ? d_req_valid : i_req_valid)
            exp_resp.push_back('{mdl_owner_d, m_resp_data, cyc + 1});
        end
      end else if (!pending && (cyc >= ready_c + 2) && (i_req_valid || d_req_valid)) begin
        give_d = d_req_valid && !(i_req_valid && streak == MAXS);
        if (give_d) begin
          b = '{1'b1, d_req_write, d_req_size, d_req_addr, d_req_wdata,
                (d_req_write ? d_req_strobe : 8'h00), d_req_write};
          streak = i_req_valid ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
        end else begin
          b = '{1'b0, 1'b0, 3'b010, i_req_addr, 64'h0, 8'h00, 1'b1};
          streak = 0;
        end
        pending     = 1;
        grant_c     = cyc;
        mdl_owner_d = give_d;
        exp_bus.push_back(b);
      end
      i_age = i_req_valid ? i_age + 1 : 0;
      d_age = d_req_valid ? d_age + 1 : 0;
      if (i_age == 300 || d_age == 300) begin
        checks++;
        errors++;
        $display("FAIL starvation: cyc=%0d i_age=%0d d_age=%0d limit 300", cyc, i_age, d_age);
      end
    end
  end

  // Monitor
  bit   in_txn = 0;
  bit   cur_ok = 0;
  bus_t cur;

  always @(negedge clk) begin
    resp_t       r;
    logic [63:0] got;
    if (model_en) begin
      if (m_req_valid) begin
        if (!in_txn) begin
          in_txn = 1;
          if (exp_bus.size() == 0) begin
            cur_ok = 0;
            checks++;
            errors++;
            $display("FAIL bus_grant: cyc=%0d got request addr=%h expected none", cyc, m_req_addr);
          end else begin
            cur = exp_bus.pop_front();
            cur_ok = 1;
            grant_log.push_back(cur.own_d);
          end
        end
        if (cur_ok) begin
          checks++;
          if ((m_req_write !== cur.wr) || (m_req_size !== cur.sz) || (m_req_addr !== cur.addr) ||
              (m_req_strobe !== cur.strb) || (cur.chk_wd && (m_req_wdata !== cur.wdata))) begin
            errors++;
            $display("FAIL bus_req: cyc=%0d got wr=%b sz=%0d addr=%h wd=%h strb=%h expected wr=%b sz=%0d addr=%h wd=%h strb=%h",
                     cyc, m_req_write, m_req_size, m_req_addr, m_req_wdata, m_req_strobe,
                     cur.wr, cur.sz, cur.addr, cur.wdata, cur.strb);
          end
        end
      end else begin
        in_txn = 0;
      end

      while (exp_resp.size() > 0 && exp_resp[0].cyc < cyc) begin
        r = exp_resp.pop_front();
        checks++;
        errors++;
        $display("FAIL resp_missing: got no pulse at cyc=%0d expected own_d=%b data=%h", r.cyc, r.own_d, r.data);
      end
      if (i_resp_ok && d_resp_ok) begin
        checks++;
        errors++;
        $display("FAIL resp_exclusive: cyc=%0d got both i_resp_ok and d_resp_ok expected at most one", cyc);
      end
      if (i_resp_ok || d_resp_ok) begin
        if (d_resp_ok) d_ok_cnt++;
        else i_ok_cnt++;
        got = d_resp_ok ? d_resp_data : i_resp_data;
        checks++;
        if (exp_resp.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: cyc=%0d got own_d=%b data=%h expected none", cyc, d_resp_ok, got);
        end else begin
          r = exp_resp.pop_front();
          if ((r.own_d != d_resp_ok) || (got !== r.data) || (r.cyc != cyc)) begin
            errors++;
            $display("FAIL resp: got own_d=%b data=%h cyc=%0d expected own_d=%b data=%h cyc=%0d",
                     d_resp_ok, got, cyc, r.own_d, r.data, r.cyc);
          end
        end
      end
    end
  end

  // Stimulus: requesters and bus responder, updated 1 time unit after each rising edge
  bit bus_en = 1, bus_rand = 0, flush_en = 0, d_scramble = 0;
  bit i_auto = 0, d_auto = 0, i_cont = 0, d_cont = 0;
  bit i_done = 0, d_done = 0, i_fl = 0, d_fl = 0;
  int bus_cnt = 0, bus_delay = 2;

  task automatic new_i();
    i_req_valid = 1'b1;
    i_req_addr  = {$urandom, $urandom};
  endtask

  task automatic new_d();
    d_req_valid  = 1'b1;
    d_req_write  = 1'($urandom_range(0, 1));
    d_req_size   = 3'($urandom_range(0, 3));
    d_req_addr   = {$urandom, $urandom};
    d_req_wdata  = {$urandom, $urandom};
    d_req_strobe = 8'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (m_resp_ready) begin
      m_resp_ready = 1'b0;
      bus_cnt = 0;
    end else if (m_req_valid && bus_en) begin
      bus_cnt++;
      if (bus_cnt > bus_delay) begin
        m_resp_ready = 1'b1;
        m_resp_data  = {$urandom, $urandom};
        if (bus_rand) bus_delay = $urandom_range(0, 3);
      end
    end
    if (i_req_valid) begin
      if (i_resp_ok) i_done = 1;
      else if (i_done) begin
        i_done = 0;
        if (i_cont || (i_auto && $urandom_range(0, 1) == 1)) new_i();
        else i_req_valid = 1'b0;
      end else if (flush_en && m_req_valid && $urandom_range(0, 15) == 0) begin
        i_req_valid = 1'b0;
        i_fl = 1;
      end
    end else begin
      if (!busy) i_fl = 0;
      if (!i_fl && i_auto && $urandom_range(0, 3) == 0) new_i();
    end
    if (d_req_valid) begin
      if (d_resp_ok) d_done = 1;
      else if (d_done) begin
        d_done = 0;
        if (d_cont || (d_auto && $urandom_range(0, 1) == 1)) new_d();
        else d_req_valid = 1'b0;
      end else if (flush_en && m_req_valid && $urandom_range(0, 15) == 0) begin
        d_req_valid = 1'b0;
        d_fl = 1;
      end else if (d_scramble && m_req_valid) begin
        d_req_wdata = {$urandom, $urandom};
      end
    end else begin
      if (!busy) d_fl = 0;
      if (!d_fl && d_auto && $urandom_range(0, 3) == 0) new_d();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus_en = 0;
    m_resp_ready = 1'b0;
    bus_cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus_en = 1;
  endtask

  initial begin
    int cnt0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 3;
    if ({i_resp_ok, d_resp_ok, m_req_valid, m_req_write, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ok_i=%b ok_d=%b mv=%b mw=%b busy=%b expected all 0",
               i_resp_ok, d_resp_ok, m_req_valid, m_req_write, busy);
    end
    if ({i_resp_data, d_resp_data} !== 128'h0) begin
      errors++;
      $display("FAIL reset_rdata: got i=%h d=%h expected 0", i_resp_data, d_resp_data);
    end
    if ({m_req_size, m_req_addr, m_req_wdata, m_req_strobe} !== '0) begin
      errors++;
      $display("FAIL reset_mreq: got sz=%0d addr=%h wd=%h strb=%h expected 0",
               m_req_size, m_req_addr, m_req_wdata, m_req_strobe);
    end
    model_en = 1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // I-only fetch, bus ready two cycles after m_req_valid
    bus_delay   = 2;
    i_req_addr  = 64'h8000_0000;
    i_req_valid = 1'b1;
    repeat (10) step();

    // Simultaneous I and D: D first
    grant_log.delete();
    new_i();
    new_d();
    repeat (16) step();
    checks++;
    if (grant_log.size() < 2 || grant_log[0] != 1'b1 || grant_log[1] != 1'b0) begin
      errors++;
      $display("FAIL both_valid_order: got %0d grants first=%b expected D then I",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : 1'b0);
    end

    // Starvation limit: D,D,D,D,I,D
    do_reset();
    grant_log.delete();
    new_i();
    new_d();
    d_cont = 1;
    for (int k = 0; k < 100 && grant_log.size() < 6; k++) step();
    d_cont = 0;
    checks++;
    if (grant_log.size() < 6) begin
      errors++;
      $display("FAIL streak_timeout: got %0d grants expected 6", grant_log.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (grant_log[k] != ((k == 4) ? 1'b0 : 1'b1)) begin
          errors++;
          $display("FAIL streak_order: grant %0d got own_d=%b expected %b",
                   k, grant_log[k], (k == 4) ? 1'b0 : 1'b1);
          break;
        end
      end
    end
    repeat (20) step();

    // Store with store data changing during WAITING
    cnt0 = d_ok_cnt;
    d_req_write  = 1'b1;
    d_req_size   = 3'd3;
    d_req_addr   = 64'h100;
    d_req_wdata  = 64'hdead_beef;
    d_req_strobe = 8'h0f;
    d_req_valid  = 1'b1;
    d_scramble   = 1;
    repeat (12) step();
    d_scramble = 0;
    checks++;
    if (d_ok_cnt - cnt0 != 1) begin
      errors++;
      $display("FAIL store_pulses: got %0d d_resp_ok pulses expected 1", d_ok_cnt - cnt0);
    end

    // Fetch withdrawn during WAITING
    cnt0 = i_ok_cnt;
    new_i();
    for (int k = 0; k < 6 && !m_req_valid; k++) step();
    checks++;
    if (!m_req_valid) begin
      errors++;
      $display("FAIL flush_grant_timeout: got m_req_valid=0 expected 1");
    end else begin
      i_req_valid = 1'b0;
      i_fl = 1;
    end
    repeat (10) step();
    checks++;
    if (i_ok_cnt != cnt0) begin
      errors++;
      $display("FAIL flush_resp: got %0d i_resp_ok pulses expected 0", i_ok_cnt - cnt0);
    end

    // Reset during WAITING, then a fresh D request
    new_d();
    d_req_write = 1'b0;
    for (int k = 0; k < 6 && !m_req_valid; k++) step();
    do_reset();
    cnt0 = d_ok_cnt;
    new_d();
    repeat (12) step();
    checks++;
    if (d_ok_cnt - cnt0 != 1) begin
      errors++;
      $display("FAIL post_reset_d: got %0d d_resp_ok pulses expected 1", d_ok_cnt - cnt0);
    end

    // Randomized traffic with flushes and variable bus latency
    do_reset();
    bus_rand = 1;
    flush_en = 1;
    i_auto   = 1;
    d_auto   = 1;
    repeat (3000) step();
    i_auto   = 0;
    d_auto   = 0;
    flush_en = 0;
    for (int k = 0; k < 200 && (i_req_valid || d_req_valid || busy); k++) step();
    repeat (3) step();
    checks++;
    if (i_req_valid || d_req_valid || busy || exp_bus.size() != 0 || exp_resp.size() != 0) begin
      errors++;
      $display("FAIL drain: got iv=%b dv=%b busy=%b bus_q=%0d resp_q=%0d expected all idle and empty",
               i_req_valid, d_req_valid, busy, exp_bus.size(), exp_resp.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
